// File: rtl/pwm_ramp_ctrl.sv
// PWM duty controller: shadowed configuration, period-aligned commit and
// linear duty ramping toward a target clamped to the effective period.
module pwm_ramp_ctrl #(
  parameter int CNT_WIDTH             = 32,
  parameter int DEFAULT_PERIOD_CYCLES = 5000,
  parameter int RAMP_DIV              = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_req,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_duty,
  input  logic [CNT_WIDTH-1:0] cfg_step,
  input  logic                 period_start,
  input  logic                 period_end,
  output logic                 tb_enable,
  output logic [CNT_WIDTH-1:0] tb_period_cycles,
  output logic [CNT_WIDTH-1:0] duty_cycles,
  output logic [1:0]           state_o,
  output logic                 update_pulse,
  output logic                 ramp_done
);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RUN     = 2'd1,
    ST_PENDING = 2'd2,
    ST_RAMP    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_TWO    = {{(CNT_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);
  localparam logic [7:0]           DIV_LAST   = 8'(RAMP_DIV - 1);

  function automatic logic [CNT_WIDTH-1:0] eff_period(input logic [CNT_WIDTH-1:0] p);
    logic [CNT_WIDTH-1:0] r;
    if (p == CNT_ZERO) begin
      r = DEF_PERIOD;
    end else if (p == CNT_ONE) begin
      r = CNT_TWO;
    end else begin
      r = p;
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] clamp_target(input logic [CNT_WIDTH-1:0] d,
                                                        input logic [CNT_WIDTH-1:0] p);
    logic [CNT_WIDTH-1:0] e;
    e = eff_period(p);
    return (d > e) ? e : d;
  endfunction

  // Adds or subtracts only when the gap exceeds the step, so no wrap or overshoot.
  function automatic logic [CNT_WIDTH-1:0] step_toward(input logic [CNT_WIDTH-1:0] duty,
                                                       input logic [CNT_WIDTH-1:0] tgt,
                                                       input logic [CNT_WIDTH-1:0] stp);
    logic [CNT_WIDTH-1:0] r;
    if (duty < tgt) begin
      r = ((tgt - duty) <= stp) ? tgt : duty + stp;
    end else begin
      r = ((duty - tgt) <= stp) ? tgt : duty - stp;
    end
    return r;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [CNT_WIDTH-1:0] target_r, step_r;
  logic [CNT_WIDTH-1:0] sh_period_r, sh_duty_r, sh_step_r;
  logic [7:0]           div_r, div_nxt_s;
  logic                 en_nxt_s, upd_nxt_s, done_nxt_s, ready_nxt_s;
  logic [CNT_WIDTH-1:0] per_nxt_s, duty_nxt_s, tgt_nxt_s, step_nxt_s;
  logic [CNT_WIDTH-1:0] sh_per_nxt_s, sh_duty_nxt_s, sh_step_nxt_s;
  logic                 hs_s;
  logic [CNT_WIDTH-1:0] act_per_s, act_tgt_s, act_step_s;
  logic [CNT_WIDTH-1:0] pend_tgt_s, ramp_duty_s;
  logic                 unused_period_start_s;

  // period_start is timebase bookkeeping only and feeds no control decision.
  assign unused_period_start_s = period_start;

  assign hs_s        = cfg_valid & cfg_ready;
  assign act_per_s   = hs_s ? cfg_period : tb_period_cycles;
  assign act_tgt_s   = hs_s ? clamp_target(cfg_duty, cfg_period) : target_r;
  assign act_step_s  = hs_s ? cfg_step : step_r;
  assign pend_tgt_s  = clamp_target(sh_duty_r, sh_period_r);
  assign ramp_duty_s = step_toward(duty_cycles, target_r, step_r);
  assign ready_nxt_s = (state_nxt_s == ST_OFF) || (state_nxt_s == ST_RUN);
  assign state_o     = state_r;

  // Next-state and next-output decode; a dropped enable overrides everything else.
  always_comb begin
    state_nxt_s   = state_r;
    en_nxt_s      = tb_enable;
    per_nxt_s     = tb_period_cycles;
    duty_nxt_s    = duty_cycles;
    tgt_nxt_s     = target_r;
    step_nxt_s    = step_r;
    div_nxt_s     = div_r;
    upd_nxt_s     = 1'b0;
    done_nxt_s    = 1'b0;
    sh_per_nxt_s  = hs_s ? cfg_period : sh_period_r;
    sh_duty_nxt_s = hs_s ? cfg_duty : sh_duty_r;
    sh_step_nxt_s = hs_s ? cfg_step : sh_step_r;
    if ((state_r != ST_OFF) && !enable_req) begin
      state_nxt_s = ST_OFF;
      en_nxt_s    = 1'b0;
      duty_nxt_s  = CNT_ZERO;
      div_nxt_s   = 8'd0;
    end else begin
      case (state_r)
        ST_OFF: begin
          per_nxt_s  = act_per_s;
          tgt_nxt_s  = act_tgt_s;
          step_nxt_s = act_step_s;
          upd_nxt_s  = hs_s;
          if (enable_req) begin
            en_nxt_s = 1'b1;
            if (act_step_s != CNT_ZERO) begin
              state_nxt_s = ST_RAMP;
              duty_nxt_s  = CNT_ZERO;
              div_nxt_s   = 8'd0;
            end else begin
              state_nxt_s = ST_RUN;
              duty_nxt_s  = act_tgt_s;
            end
          end else begin
            en_nxt_s   = 1'b0;
            duty_nxt_s = CNT_ZERO;
          end
        end
        ST_RUN: begin
          if (hs_s) begin
            state_nxt_s = ST_PENDING;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_PENDING: begin
          if (period_end) begin
            per_nxt_s  = sh_period_r;
            tgt_nxt_s  = pend_tgt_s;
            step_nxt_s = sh_step_r;
            upd_nxt_s  = 1'b1;
            if ((sh_step_r == CNT_ZERO) || (duty_cycles == pend_tgt_s)) begin
              state_nxt_s = ST_RUN;
              duty_nxt_s  = pend_tgt_s;
            end else begin
              state_nxt_s = ST_RAMP;
              div_nxt_s   = 8'd0;
            end
          end else begin
            state_nxt_s = ST_PENDING;
          end
        end
        ST_RAMP: begin
          if (period_end) begin
            if (div_r == DIV_LAST) begin
              div_nxt_s  = 8'd0;
              duty_nxt_s = ramp_duty_s;
              if (ramp_duty_s == target_r) begin
                state_nxt_s = ST_RUN;
                done_nxt_s  = 1'b1;
              end else begin
                state_nxt_s = ST_RAMP;
              end
            end else begin
              div_nxt_s = div_r + 8'd1;
            end
          end else begin
            state_nxt_s = ST_RAMP;
          end
        end
        default: begin
          state_nxt_s = ST_OFF;
          en_nxt_s    = 1'b0;
          duty_nxt_s  = CNT_ZERO;
          div_nxt_s   = 8'd0;
        end
      endcase
    end
  end

  // State, active/shadow configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_OFF;
      cfg_ready        <= 1'b1;
      tb_enable        <= 1'b0;
      tb_period_cycles <= CNT_ZERO;
      duty_cycles      <= CNT_ZERO;
      target_r         <= CNT_ZERO;
      step_r           <= CNT_ZERO;
      div_r            <= 8'd0;
      update_pulse     <= 1'b0;
      ramp_done        <= 1'b0;
      sh_period_r      <= CNT_ZERO;
      sh_duty_r        <= CNT_ZERO;
      sh_step_r        <= CNT_ZERO;
    end else begin
      state_r          <= state_nxt_s;
      cfg_ready        <= ready_nxt_s;
      tb_enable        <= en_nxt_s;
      tb_period_cycles <= per_nxt_s;
      duty_cycles      <= duty_nxt_s;
      target_r         <= tgt_nxt_s;
      step_r           <= step_nxt_s;
      div_r            <= div_nxt_s;
      update_pulse     <= upd_nxt_s;
      ramp_done        <= done_nxt_s;
      sh_period_r      <= sh_per_nxt_s;
      sh_duty_r        <= sh_duty_nxt_s;
      sh_step_r        <= sh_step_nxt_s;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: a transaction-level model predicts each
// observable output change; a monitor compares every change the DUT shows.
module tb_pwm_ramp_ctrl;
  localparam int W     = 32;
  localparam int DEF_P = 5000;
  localparam int DIV   = 1;
  localparam int M_OFF = 0, M_RUN = 1, M_PEND = 2, M_RAMP = 3;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         enable_req = 1'b0, cfg_valid = 1'b0, period_start = 1'b0, period_end = 1'b0;
  logic [W-1:0] cfg_period = '0, cfg_duty = '0, cfg_step = '0;
  logic         cfg_ready, tb_enable, update_pulse, ramp_done;
  logic [W-1:0] tb_period_cycles, duty_cycles;
  logic [1:0]   state_o;

  pwm_ramp_ctrl #(.CNT_WIDTH(W), .DEFAULT_PERIOD_CYCLES(DEF_P), .RAMP_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable_req(enable_req), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_step(cfg_step),
    .period_start(period_start), .period_end(period_end), .tb_enable(tb_enable),
    .tb_period_cycles(tb_period_cycles), .duty_cycles(duty_cycles), .state_o(state_o),
    .update_pulse(update_pulse), .ramp_done(ramp_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   st;
    logic [W-1:0] duty;
    logic         en;
    logic [W-1:0] per;
    logic         upd;
    logic         done;
    logic         rdy;
  } snap_t;

  snap_t  exp_q[$];
  int     tests = 0;
  int     fails = 0;
  bit     mon_on = 1'b0;
  snap_t  mon_prev;

  // reference model state
  int           m_mode = M_OFF;
  logic [W-1:0] m_per = '0, m_tgt = '0, m_step = '0, m_duty = '0;
  logic [W-1:0] sh_p = '0, sh_d = '0, sh_s = '0;
  bit           m_en = 1'b0, m_upd = 1'b0, m_done = 1'b0;
  int           m_div = 0;
  longint       ramp_q[$];
  snap_t        m_prev;

  function automatic snap_t reset_snap();
    snap_t s;
    s.st = 2'd0; s.duty = '0; s.en = 1'b0; s.per = '0;
    s.upd = 1'b0; s.done = 1'b0; s.rdy = 1'b1;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.st = state_o; s.duty = duty_cycles; s.en = tb_enable; s.per = tb_period_cycles;
    s.upd = update_pulse; s.done = ramp_done; s.rdy = cfg_ready;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d duty=%0d en=%0b per=%0d upd=%0b done=%0b rdy=%0b",
                     s.st, s.duty, s.en, s.per, s.upd, s.done, s.rdy);
  endfunction

  function automatic longint eff(input longint p);
    if (p == 0) return DEF_P;
    if (p == 1) return 2;
    return p;
  endfunction

  function automatic logic [W-1:0] tmin(input longint d, input longint p);
    longint e;
    e = eff(p);
    return W'((d < e) ? d : e);
  endfunction

  // The whole ramp as an arithmetic sequence: ceil(gap/step) values ending on target.
  task automatic build_ramp();
    longint d, t, s, gap, n;
    d = m_duty; t = m_tgt; s = m_step;
    ramp_q.delete();
    gap = (t > d) ? t - d : d - t;
    n = (gap + s - 1) / s;
    for (longint k = 1; k < n; k++) ramp_q.push_back((t > d) ? d + k * s : d - k * s);
    if (n > 0) ramp_q.push_back(t);
  endtask

  task automatic model_step(input bit en, input bit cv, input logic [W-1:0] p,
                            input logic [W-1:0] d, input logic [W-1:0] s, input bit pe);
    bit hs;
    snap_t ns;
    hs = cv && (m_mode == M_OFF || m_mode == M_RUN);
    m_upd = 1'b0; m_done = 1'b0;
    if (m_mode != M_OFF && !en) begin
      m_mode = M_OFF; m_en = 1'b0; m_duty = '0;
    end else begin
      case (m_mode)
        M_OFF: begin
          if (hs) begin m_per = p; m_tgt = tmin(d, p); m_step = s; m_upd = 1'b1; end
          if (en) begin
            m_en = 1'b1;
            if (m_step != 0) begin m_mode = M_RAMP; m_duty = '0; m_div = 0; build_ramp(); end
            else begin m_mode = M_RUN; m_duty = m_tgt; end
          end
        end
        M_RUN: if (hs) begin sh_p = p; sh_d = d; sh_s = s; m_mode = M_PEND; end
        M_PEND: if (pe) begin
          m_per = sh_p; m_tgt = tmin(sh_d, sh_p); m_step = sh_s; m_upd = 1'b1;
          if (m_step == 0 || m_duty == m_tgt) begin m_duty = m_tgt; m_mode = M_RUN; end
          else begin m_mode = M_RAMP; m_div = 0; build_ramp(); end
        end
        M_RAMP: if (pe) begin
          m_div++;
          if (m_div == DIV) begin
            m_div = 0;
            if (ramp_q.size() > 0) m_duty = W'(ramp_q.pop_front());
            if (ramp_q.size() == 0) begin m_mode = M_RUN; m_done = 1'b1; end
          end
        end
        default: ;
      endcase
    end
    ns.st = 2'(m_mode); ns.duty = m_duty; ns.en = m_en; ns.per = m_per;
    ns.upd = m_upd; ns.done = m_done; ns.rdy = (m_mode == M_OFF || m_mode == M_RUN);
    if (ns != m_prev) exp_q.push_back(ns);
    m_prev = ns;
  endtask

  task automatic tick(input bit en, input bit cv, input logic [W-1:0] p,
                      input logic [W-1:0] d, input logic [W-1:0] s, input bit pe);
    enable_req = en; cfg_valid = cv; cfg_period = p; cfg_duty = d; cfg_step = s;
    period_end = pe; period_start = pe;
    model_step(en, cv, p, d, s, pe);
    @(posedge clk); #1;
    cfg_valid = 1'b0; period_end = 1'b0; period_start = 1'b0;
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) tick(en, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // One timebase period of 10 cycles, period_end on its first cycle.
  task automatic one_period(input bit en);
    tick(en, 1'b0, '0, '0, '0, 1'b1);
    idle(9, en);
  endtask

  task automatic chk(input string name, input longint got, input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_tb_enable"}, tb_enable, 0);
    chk({tag, "_period"}, tb_period_cycles, 0);
    chk({tag, "_duty"}, duty_cycles, 0);
    chk({tag, "_update"}, update_pulse, 0);
    chk({tag, "_ramp_done"}, ramp_done, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
  endtask

  task automatic monitor_loop();
    snap_t obs, want;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        obs = dut_snap();
        if (obs != mon_prev) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got %s", fmt(obs));
          end else begin
            want = exp_q.pop_front();
            if (obs != want) begin
              fails++;
              $display("FAIL event: got %s, expected %s", fmt(obs), fmt(want));
            end
          end
          mon_prev = obs;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF; m_per = '0; m_tgt = '0; m_step = '0; m_duty = '0;
    m_en = 1'b0; m_div = 0; ramp_q.delete();
    if (m_prev != reset_snap()) exp_q.push_back(reset_snap());
    m_prev = reset_snap();
  endtask

  initial begin
    m_prev   = reset_snap();
    mon_prev = reset_snap();
    fork
      monitor_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // configure in OFF (first edge after release), then ramp 0,2,4,6
    tick(1'b0, 1'b1, 32'd10, 32'd6, 32'd2, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    repeat (4) one_period(1'b1);

    // RUN at 6 -> pending -> ramp down 4,2,1
    tick(1'b1, 1'b1, 32'd10, 32'd1, 32'd2, 1'b0);
    chk("pending_cfg_ready", cfg_ready, 0);
    repeat (5) one_period(1'b1);

    // handshake coincident with period_end commits one period later
    tick(1'b1, 1'b1, 32'd10, 32'd7, 32'd0, 1'b1);
    idle(9, 1'b1);
    one_period(1'b1);

    // default-period and period=1 clamping
    tick(1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b0, 1'b1, 32'd0, 32'd9000, 32'd0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b1, 1'b1, 32'd1, 32'd5, 32'd0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b1);
    idle(2, 1'b1);

    // enable dropped mid-ramp
    tick(1'b1, 1'b1, 32'd10, 32'd9, 32'd3, 1'b0);
    one_period(1'b1);
    one_period(1'b1);
    tick(1'b0, 1'b0, '0, '0, '0, 1'b0);

    // enable dropped in PENDING together with period_end; active config retained
    tick(1'b0, 1'b1, 32'd10, 32'd4, 32'd0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b1, 1'b1, 32'd10, 32'd8, 32'd0, 1'b0);
    tick(1'b0, 1'b0, '0, '0, '0, 1'b1);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1)) : W'($urandom_range(2, 20));
      tick($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0, rp,
           W'($urandom_range(0, 25)), W'($urandom_range(0, 5)), $urandom_range(0, 3) == 0);
    end

    // asynchronous reset mid-ramp, between clock edges
    tick(1'b0, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b0, 1'b1, 32'd10, 32'd8, 32'd1, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b1);
    idle(2, 1'b1);
    chk("pre_reset_in_ramp", state_o, M_RAMP);
    #2;
    enable_req = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 32'd10, 32'd3, 32'd0, 1'b0);
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(3, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
